// File: rtl/gpio_access_arbiter.sv
// gpio_access_arbiter: round-robin share of one GPIO slave among NUM_REQ requesters.
// Each access is IDLE (grant) -> ISSUE (one-cycle GPIO strobe) -> RESP (response pulse).
// Optional build macro GPIO_ARB_ERRCHK_EN: illegal accesses are blocked before the GPIO
// and answered with rsp_err=1. Without it every access is forwarded and rsp_err is 0.
module gpio_access_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int GPIO_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ-1:0]      req_we,
    input  logic [3*NUM_REQ-1:0]    req_addr,
    input  logic [32*NUM_REQ-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic [NUM_REQ-1:0]      rsp_valid,
    output logic [31:0]             rsp_rdata,
    output logic                    rsp_err,
    output logic                    gpio_en,
    output logic                    gpio_we,
    output logic                    gpio_re,
    output logic [2:0]              gpio_addr,
    output logic [1:0]              gpio_size,
    output logic [31:0]             gpio_wd_data,
    input  logic [31:0]             gpio_rd_data,
    input  logic                    gpio_done
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    // Largest write value that fits in one GPIO port.
    localparam logic [31:0] WMAX = (GPIO_WIDTH >= 32) ? 32'hFFFF_FFFF
                                                      : ((32'd1 << GPIO_WIDTH) - 32'd1);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t            state, state_nxt;
    logic [IDX_W-1:0]  rr_ptr, grant, win_idx;
    logic [IDX_W:0]    cand;
    logic              win_found;
    logic              lat_we;
    logic [2:0]        lat_addr;
    logic [31:0]       lat_wdata;
    logic              acc_legal, fwd, err_q;
    logic [2:0]        addr_a  [NUM_REQ];
    logic [31:0]       wdata_a [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_a[g]  = req_addr[3*g +: 3];
        assign wdata_a[g] = req_wdata[32*g +: 32];
    end

    // Writes target the output ports (addr 4..7) and must fit the port; reads target 0..3.
    assign acc_legal = lat_we ? (lat_addr[2] && (lat_wdata <= WMAX)) : !lat_addr[2];

`ifdef GPIO_ARB_ERRCHK_EN
    assign fwd = acc_legal;
`else
    // Legality has no consumer here; the name keeps it out of unused-signal reports.
    logic unused_legal;
    assign unused_legal = acc_legal;
    assign fwd = 1'b1;
`endif

    assign gpio_size = 2'b00;
    assign rsp_err   = err_q;

    // Round-robin search: first pending requester at or after rr_ptr, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(NUM_REQ))
                cand = cand - (IDX_W+1)'(NUM_REQ);
            if (!win_found && req_valid[cand[IDX_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IDX_W-1:0];
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state; ISSUE also waits on gpio_done so a slower slave can stretch the strobe.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (win_found) state_nxt = ISSUE;
            ISSUE:   if (gpio_done) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Command latch, read-data capture and round-robin pointer update.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr    <= '0;
            grant     <= '0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            rsp_rdata <= '0;
            err_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (win_found) begin
                    grant     <= win_idx;
                    lat_we    <= req_we[win_idx];
                    lat_addr  <= addr_a[win_idx];
                    lat_wdata <= wdata_a[win_idx];
                end
                ISSUE: if (gpio_done) begin
                    rsp_rdata <= (fwd && !lat_we) ? gpio_rd_data : 32'h0;
                    err_q     <= !fwd;
                end
                RESP: rr_ptr <= (grant == IDX_W'(NUM_REQ-1)) ? '0 : grant + 1'b1;
                default: ;
            endcase
        end
    end

    // Outputs: accept pulse in IDLE, GPIO strobe in ISSUE, response pulse in RESP.
    // A reset cycle suppresses both pulses so an aborted access leaves no trace.
    always_comb begin
        req_ready    = '0;
        rsp_valid    = '0;
        gpio_en      = 1'b0;
        gpio_we      = 1'b0;
        gpio_re      = 1'b0;
        gpio_addr    = '0;
        gpio_wd_data = '0;
        case (state)
            IDLE: if (win_found && !rst) req_ready[win_idx] = 1'b1;
            ISSUE: if (fwd) begin
                gpio_en      = 1'b1;
                gpio_we      = lat_we;
                gpio_re      = !lat_we;
                gpio_addr    = lat_addr;
                gpio_wd_data = lat_wdata;
            end
            RESP: if (!rst) rsp_valid[grant] = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_gpio_access_arbiter.sv
// tb_gpio_access_arbiter: directed + random accesses against a behavioural model
// (round-robin pick rule, legality rules, and a simple GPIO slave with a sticky check flag).
module tb_gpio_access_arbiter;
    localparam int N = 4;
`ifdef GPIO_ARB_ERRCHK_EN
    localparam bit ERRCHK = 1'b1;
`else
    localparam bit ERRCHK = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid, req_we, req_ready, rsp_valid;
    logic [3*N-1:0]  req_addr;
    logic [32*N-1:0] req_wdata;
    logic [31:0]     rsp_rdata, gpio_wd_data, gpio_rd_data;
    logic            rsp_err, gpio_en, gpio_we, gpio_re;
    logic [2:0]      gpio_addr;
    logic [1:0]      gpio_size;
    logic            gpio_done = 1'b1;

    gpio_access_arbiter #(.NUM_REQ(N), .GPIO_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .gpio_en(gpio_en), .gpio_we(gpio_we), .gpio_re(gpio_re),
        .gpio_addr(gpio_addr), .gpio_size(gpio_size), .gpio_wd_data(gpio_wd_data),
        .gpio_rd_data(gpio_rd_data), .gpio_done(gpio_done)
    );

    always #5 clk = ~clk;

    // GPIO slave: four input ports read at 0..3, four output ports written at 4..7,
    // sticky check flag on any illegal strobe.
    logic [7:0] in_port  [4];
    logic [7:0] out_port [4];
    logic       chk_flag = 1'b0;
    assign gpio_rd_data = (gpio_en && gpio_re && !gpio_addr[2]) ? {24'h0, in_port[gpio_addr[1:0]]} : 32'h0;
    always @(posedge clk) begin
        if (gpio_en && gpio_we) begin
            if (!gpio_addr[2] || gpio_wd_data > 32'hFF) chk_flag <= 1'b1;
            else out_port[gpio_addr[1:0]] <= gpio_wd_data[7:0];
        end
        if (gpio_en && gpio_re && gpio_addr[2]) chk_flag <= 1'b1;
    end

    int          n_chk = 0, n_fail = 0;
    int          m_ptr = 0;
    bit          m_check = 1'b0;
    logic [N-1:0] pend = '0;
    logic        c_we [N];
    logic [2:0]  c_addr [N];
    logic [31:0] c_wd [N];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        req_valid = pend;
        for (int i = 0; i < N; i++) begin
            req_we[i]           = c_we[i];
            req_addr[3*i +: 3]  = c_addr[i];
            req_wdata[32*i +: 32] = c_wd[i];
        end
    endtask

    task automatic rand_cmd(input int i);
        c_we[i]   = 1'($urandom_range(0, 1));
        c_addr[i] = 3'($urandom_range(0, 7));
        c_wd[i]   = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 255));
    endtask

    function automatic int pick(input logic [N-1:0] m, input int p);
        for (int k = 0; k < N; k++)
            if (m[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    task automatic do_reset();
        rst = 1'b1; pend = '0; drive();
        @(posedge clk); #1;
        rst = 1'b0; m_ptr = 0;
        #1;
        check("rst_req_ready", 32'(req_ready), 32'h0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_rsp_err", 32'(rsp_err), 32'h0);
        check("rst_gpio_strb", {29'h0, gpio_en, gpio_we, gpio_re}, 32'h0);
        check("rst_gpio_addr", 32'(gpio_addr), 32'h0);
        check("rst_gpio_size", 32'(gpio_size), 32'h0);
        check("rst_gpio_wd", gpio_wd_data, 32'h0);
    endtask

    // One full access from an IDLE cycle with requests already driven.
    // keep=1: the winner immediately presents a fresh random command.
    task automatic access(input bit keep, output int w);
        bit          cw, legal, fwd;
        logic [2:0]  ca;
        logic [31:0] cd, erd;
        w = pick(pend, m_ptr);
        #1;
        check("grant_ready", 32'(req_ready), 32'(1 << w));
        check("idle_rsp_valid", 32'(rsp_valid), 32'h0);
        check("idle_gpio_en", 32'(gpio_en), 32'h0);
        cw = c_we[w]; ca = c_addr[w]; cd = c_wd[w];
        legal = cw ? (ca >= 3'd4 && cd <= 32'hFF) : (ca <= 3'd3);
        fwd   = !ERRCHK || legal;
        erd   = (!fwd || cw) ? 32'h0 : ((ca <= 3'd3) ? {24'h0, in_port[ca[1:0]]} : 32'h0);
        @(posedge clk); #1;
        if (keep) rand_cmd(w); else pend[w] = 1'b0;
        drive(); #1;
        check("issue_ready", 32'(req_ready), 32'h0);
        check("issue_en", 32'(gpio_en), 32'(fwd));
        check("issue_we", 32'(gpio_we), 32'(fwd && cw));
        check("issue_re", 32'(gpio_re), 32'(fwd && !cw));
        if (fwd) check("issue_addr", 32'(gpio_addr), 32'(ca));
        if (fwd && cw) check("issue_wdata", gpio_wd_data, cd);
        if (fwd && !legal) m_check = 1'b1;
        @(posedge clk); #1;
        check("resp_valid", 32'(rsp_valid), 32'(1 << w));
        check("resp_rdata", rsp_rdata, erd);
        check("resp_err", 32'(rsp_err), 32'(ERRCHK && !legal));
        check("resp_gpio_en", 32'(gpio_en), 32'h0);
        check("gpio_check", 32'(chk_flag), 32'(m_check));
        if (fwd && cw && legal) check("gpio_out_port", 32'(out_port[ca[1:0]]), 32'(cd[7:0]));
        m_ptr = (w + 1) % N;
        @(posedge clk); #1;
        check("hold_rdata", rsp_rdata, erd);
    endtask

    int w;
    initial begin
        for (int i = 0; i < 4; i++) begin
            in_port[i] = 8'($urandom); out_port[i] = 8'h0; c_we[i] = 0; c_addr[i] = 0; c_wd[i] = 0;
        end
        in_port[1] = 8'hA5;
        rst = 1'b1; drive();
        @(posedge clk); #1;
        do_reset();

        // Requester 2 reads port B.
        c_we[2] = 0; c_addr[2] = 3'b001; pend = 4'b0100; drive();
        access(0, w);
        // Requester 0 writes 0x3C to port C.
        c_we[0] = 1; c_addr[0] = 3'b110; c_wd[0] = 32'h3C; pend = 4'b0001; drive();
        access(0, w);
        check("portC", 32'(out_port[2]), 32'h3C);

        // No requests: nothing granted.
        pend = '0; drive();
        repeat (3) begin
            @(posedge clk); #1;
            check("idle_no_grant", 32'(req_ready), 32'h0);
            check("idle_no_strobe", 32'(gpio_en), 32'h0);
        end

        // All requesters continuously, 12 accesses, order 0,1,2,3 x3.
        do_reset();
        for (int i = 0; i < N; i++) rand_cmd(i);
        pend = '1; drive();
        for (int k = 0; k < 12; k++) begin
            access(1, w);
            check("rr_order", 32'(w), 32'(k % N));
        end

        // Legality boundaries.
        pend = '0; drive();
        c_we[1] = 1; c_addr[1] = 3'b000; c_wd[1] = 32'h12;  pend = 4'b0010; drive(); access(0, w);
        c_we[1] = 1; c_addr[1] = 3'b100; c_wd[1] = 32'h1FF; pend = 4'b0010; drive(); access(0, w);
        c_we[1] = 1; c_addr[1] = 3'b111; c_wd[1] = 32'hFF;  pend = 4'b0010; drive(); access(0, w);
        c_we[3] = 0; c_addr[3] = 3'b011; pend = 4'b1000; drive(); access(0, w);
        c_we[3] = 0; c_addr[3] = 3'b101; pend = 4'b1000; drive(); access(0, w);

        // Random traffic; pending requests may also be withdrawn before grant.
        for (int k = 0; k < 40; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 2) != 0) begin rand_cmd(i); pend[i] = 1'b1; end
                else if (pend[i] && $urandom_range(0, 9) == 0) pend[i] = 1'b0;
            end
            drive();
            if (pend == '0) begin
                #1 check("rand_idle", 32'(req_ready), 32'h0);
                @(posedge clk); #1;
            end else access(0, w);
        end

        // Reset during RESP of requester 1 aborts it and clears rr_ptr.
        pend = '0; drive();
        @(posedge clk); #1;
        c_we[1] = 0; c_addr[1] = 3'b010; pend = 4'b0010; drive();
        #1 check("mid_grant", 32'(req_ready), 32'h2);
        @(posedge clk); #1;
        pend = '0; drive();
        @(posedge clk); #1;
        rst = 1'b1;
        #1 check("mid_rst_no_rsp", 32'(rsp_valid), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0; m_ptr = 0;
        check("mid_rst_rdata", rsp_rdata, 32'h0);
        for (int i = 0; i < 3; i++) begin c_we[i] = 0; c_addr[i] = 3'(i); end
        pend = 4'b0111; drive();
        access(0, w);
        check("after_rst_first", 32'(w), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
